apb_rw_scheduler: RTL and testbench
===================================

# apb_rw_scheduler

Sequencing core of the AXI4-Lite to APB bridge. Takes decoded write requests (address + data) and read requests from the AXI4-Lite front end and shares the single APB master port between them. Write and read are granted round-robin, each transfer runs the APB SETUP/ACCESS phases, and a wait-state timeout bounds each transfer. Completion status, and read data for reads, go back to the response path.

## Interface
- addrWidth, 32, APB/AXI address width
- dataWidth, 32, data width; strobe width dataWidth/8
- TIMEOUT, 16, maximum ACCESS cycles without pready before forced error; 0 disables the timeout
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_req_valid / wr_req_ready  in/out  1  write request handshake
- wr_addr, wr_prot, wr_data, wr_strb  in  addrWidth, 3, dataWidth, dataWidth/8  write request fields
- wr_done_valid / wr_done_ready  out/in  1  write completion handshake
- wr_done_err  out  1  write completed with error (pslverr or timeout)
- rd_req_valid / rd_req_ready  in/out  1  read request handshake
- rd_addr, rd_prot  in  addrWidth, 3  read request fields
- rd_done_valid / rd_done_ready  out/in  1  read completion handshake
- rd_done_data  out  dataWidth  captured prdata
- rd_done_err  out  1  read completed with error
- psel, penable, pwrite  out  1  APB control
- paddr, pprot, pwdata, pstrb  out  addrWidth, 3, dataWidth, dataWidth/8  APB request
- prdata  in  dataWidth; pready, pslverr  in  1  APB completion

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. At most one transfer is outstanding.
- **IDLE**
  - Grant write if only wr_req_valid is high; grant read if only rd_req_valid is high.
  - If both are high, grant the channel not served last. last_grant resets to read, so write wins the first tie.
  - The granted *_req_ready is high combinationally in IDLE only. On valid & ready, register addr/prot/data/strb and pwrite, then go to SETUP.
- **SETUP**
  - psel=1, penable=0. Go to ACCESS unconditionally. Clear the timeout counter.
- **ACCESS**
  - psel=1, penable=1.
  - pready=1: capture pslverr as err and, for a read, capture prdata. Go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with pready still low, set err=1 and go to RESP.
- **RESP**
  - psel=penable=0. The granted channel's *_done_valid is high, with err/data held stable until *_done_ready.
  - On the handshake: go to IDLE and update last_grant.
- On reads, pwdata=0 and pstrb=0.
- Request fields are ignored when *_req_valid is low. A valid request is never dropped; it waits in IDLE until granted.
- The counter is $clog2(TIMEOUT+1) bits and saturates.

## Timing
- Reset values: state=IDLE, psel=penable=pwrite=0, paddr/pprot/pwdata/pstrb=0, both done_valid=0, both err=0, rd_done_data=0, both req_ready=0. Reset is asynchronous: psel and penable fall immediately.
- Reset mid-transfer abandons the transfer; no done is produced.
- Zero-wait transfer, with cycle 0 as the accept cycle: SETUP in cycle 1, ACCESS in cycle 2 (pready=1), done_valid in cycle 3. With done_ready=1 the FSM returns to IDLE in cycle 4, so the next accept is in cycle 4. Minimum period is 4 cycles per transfer.
- Each wait state adds 1 cycle.
- With TIMEOUT=N: done_valid with err=1 appears N+2 cycles after accept.
- APB outputs are registered and stay stable from SETUP through the last ACCESS cycle.
- A new request arriving during SETUP/ACCESS/RESP waits; its req_ready stays low.

## Structure
- Package apb_bridge_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP)
  - the grant enum (GNT_WR, GNT_RD)
  - localparams RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, used by the AXI response mapping
- Sub-module rr_arbiter2: a 2-requester round-robin arbiter. Inputs are the two requests plus an update strobe; outputs are grant and last_grant state.

## Test plan
- Single write, addr 0x40, data 0xDEADBEEF, strb 0xF, pready=1 in first ACCESS -> psel high cycles 1-2, penable cycle 2, pwrite=1, wr_done_valid in cycle 3 with err=0.
- Read addr 0x80, prdata 0x12345678, pready after 3 wait states -> rd_done_data=0x12345678, err=0, pwdata=0 and pstrb=0 throughout.
- wr_req_valid and rd_req_valid high together for 4 transfers -> grant order W,R,W,R.
- Write with pslverr=1 on the pready cycle -> wr_done_err=1. Write with pready never high and TIMEOUT=16 -> err=1 18 cycles after accept, psel drops.
- Hold wr_done_ready low 5 cycles -> done_valid and err stay stable, no new accept. Assert rst low during ACCESS -> psel/penable=0 immediately, state IDLE after release.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared types and constants for the AXI4-Lite to APB bridge
package apb_bridge_pkg;

  // Transfer sequencing states of the APB master
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Which request channel owns the APB port
  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_t;

  // AXI response codes produced from the completion error flag
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Map a completion error flag to an AXI BRESP/RRESP code
  function automatic logic [1:0] errToResp(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin arbiter (write vs read)
module rr_arbiter2
  import apb_bridge_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic reqWr,
  input  logic reqRd,
  input  logic update,
  output logic gntWr,
  output logic gntRd,
  output logic lastGrant
);

  grant_t lastQ;

  // A lone requester wins outright; on a tie the channel not served last wins
  always_comb begin
    gntWr = 1'b0;
    gntRd = 1'b0;
    if (reqWr && reqRd) begin
      if (lastQ == GNT_RD) begin
        gntWr = 1'b1;
      end else begin
        gntRd = 1'b1;
      end
    end else begin
      gntWr = reqWr;
      gntRd = reqRd;
    end
  end

  // Remember the channel taken on each update; starts as read so write wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastQ <= GNT_RD;
    end else if (update) begin
      lastQ <= gntWr ? GNT_WR : GNT_RD;
    end
  end

  assign lastGrant = lastQ;

endmodule

// File: rtl/apb_rw_scheduler.sv
// rtl/apb_rw_scheduler.sv - shares one APB master port between write and read requests
module apb_rw_scheduler
  import apb_bridge_pkg::*;
#(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_req_valid,
  output logic                   wr_req_ready,
  input  logic [addrWidth-1:0]   wr_addr,
  input  logic [2:0]             wr_prot,
  input  logic [dataWidth-1:0]   wr_data,
  input  logic [dataWidth/8-1:0] wr_strb,
  output logic                   wr_done_valid,
  input  logic                   wr_done_ready,
  output logic                   wr_done_err,
  input  logic                   rd_req_valid,
  output logic                   rd_req_ready,
  input  logic [addrWidth-1:0]   rd_addr,
  input  logic [2:0]             rd_prot,
  output logic                   rd_done_valid,
  input  logic                   rd_done_ready,
  output logic [dataWidth-1:0]   rd_done_data,
  output logic                   rd_done_err,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [addrWidth-1:0]   paddr,
  output logic [2:0]             pprot,
  output logic [dataWidth-1:0]   pwdata,
  output logic [dataWidth/8-1:0] pstrb,
  input  logic [dataWidth-1:0]   prdata,
  input  logic                   pready,
  input  logic                   pslverr
);

  localparam int cntWidth = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [cntWidth-1:0] cntLast = (TIMEOUT > 0) ? cntWidth'(TIMEOUT - 1) : '0;
  localparam logic [cntWidth-1:0] cntMax  = '1;
  localparam logic timeoutOn = (TIMEOUT > 0);

  state_t              state;
  logic [cntWidth-1:0] waitCnt;
  logic                gntWr;
  logic                gntRd;
  logic                lastGrant;
  grant_t              curCh;
  logic                acceptWr;
  logic                acceptRd;
  logic                accessTimeout;
  logic                doneHs;

  // The arbiter latches the channel at accept, so lastGrant names the owner for the
  // whole transfer and equals the most recently completed channel by the next IDLE
  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .reqWr     (wr_req_valid),
    .reqRd     (rd_req_valid),
    .update    (acceptWr || acceptRd),
    .gntWr     (gntWr),
    .gntRd     (gntRd),
    .lastGrant (lastGrant)
  );

  assign curCh = grant_t'(lastGrant);

  // Ready is offered only in IDLE and only to the granted, requesting channel
  always_comb begin
    wr_req_ready = rst && (state == IDLE) && gntWr;
    rd_req_ready = rst && (state == IDLE) && gntRd;
  end

  assign acceptWr      = wr_req_valid && wr_req_ready;
  assign acceptRd      = rd_req_valid && rd_req_ready;
  assign accessTimeout = timeoutOn && (waitCnt == cntLast);
  assign doneHs        = (wr_done_valid && wr_done_ready) || (rd_done_valid && rd_done_ready);

  // Transfer sequencer: registers the request, drives APB phases, holds the completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      waitCnt       <= '0;
      psel          <= 1'b0;
      penable       <= 1'b0;
      pwrite        <= 1'b0;
      paddr         <= '0;
      pprot         <= '0;
      pwdata        <= '0;
      pstrb         <= '0;
      wr_done_valid <= 1'b0;
      wr_done_err   <= 1'b0;
      rd_done_valid <= 1'b0;
      rd_done_err   <= 1'b0;
      rd_done_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acceptWr) begin
            pwrite <= 1'b1;
            paddr  <= wr_addr;
            pprot  <= wr_prot;
            pwdata <= wr_data;
            pstrb  <= wr_strb;
            psel   <= 1'b1;
            state  <= SETUP;
          end else if (acceptRd) begin
            pwrite <= 1'b0;
            paddr  <= rd_addr;
            pprot  <= rd_prot;
            pwdata <= '0;
            pstrb  <= '0;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          waitCnt <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready || accessTimeout) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            state   <= RESP;
            if (curCh == GNT_WR) begin
              wr_done_valid <= 1'b1;
              wr_done_err   <= pready ? pslverr : 1'b1;
            end else begin
              rd_done_valid <= 1'b1;
              rd_done_err   <= pready ? pslverr : 1'b1;
              rd_done_data  <= pready ? prdata : '0;
            end
          end else if (waitCnt != cntMax) begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        RESP: begin
          if (doneHs) begin
            wr_done_valid <= 1'b0;
            rd_done_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rw_scheduler.sv
// tb/tb_apb_rw_scheduler.sv - self-checking bench for apb_rw_scheduler
module tb_apb_rw_scheduler;
  import apb_bridge_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_req_valid = 1'b0, wr_req_ready;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [2:0]  wr_prot = '0;
  logic [3:0]  wr_strb = '0;
  logic        wr_done_valid, wr_done_ready = 1'b0, wr_done_err;
  logic        rd_req_valid = 1'b0, rd_req_ready;
  logic [31:0] rd_addr = '0;
  logic [2:0]  rd_prot = '0;
  logic        rd_done_valid, rd_done_ready = 1'b0, rd_done_err;
  logic [31:0] rd_done_data;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;

  apb_rw_scheduler #(.addrWidth(32), .dataWidth(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_addr(wr_addr),
    .wr_prot(wr_prot), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_done_valid(wr_done_valid), .wr_done_ready(wr_done_ready), .wr_done_err(wr_done_err),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr), .rd_prot(rd_prot),
    .rd_done_valid(rd_done_valid), .rd_done_ready(rd_done_ready), .rd_done_data(rd_done_data),
    .rd_done_err(rd_done_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pprot(pprot),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          isWr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    bit          slvErr;
    logic [31:0] rdata;
    int          readyDelay;
    bit          expErr;
    int          expDone;
    bit          chkData;
  } xfer_t;

  int          nChecks = 0;
  int          nFails = 0;
  int          cycNow = 0;
  int          slvWait = 0;
  bit          slvErr = 1'b0;
  logic [31:0] slvData = '0;
  grant_t      lastServed = GNT_RD;
  grant_t      acceptLog[$];
  int          acceptCyc[$];
  xfer_t       vec[8];
  xfer_t       dummy;

  always @(posedge clk) cycNow <= cycNow + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cycNow);
    end
  endtask

  function automatic xfer_t mk(input bit isWr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [2:0] prot, input int waits,
                               input bit sErr, input logic [31:0] rdata, input int dly,
                               input bit expErr, input int expDone, input bit chkData);
    xfer_t x;
    x.isWr = isWr; x.addr = addr; x.data = data; x.strb = strb; x.prot = prot;
    x.waits = waits; x.slvErr = sErr; x.rdata = rdata; x.readyDelay = dly;
    x.expErr = expErr; x.expDone = expDone; x.chkData = chkData;
    return x;
  endfunction

  // Reference timing: done comes 3 cycles after accept plus one per wait state,
  // unless the slave stalls TMO access cycles, then an error at TMO+2
  function automatic xfer_t model(input xfer_t x);
    if (x.waits >= TMO) begin
      x.expErr = 1'b1; x.expDone = TMO + 2; x.chkData = 1'b0;
    end else begin
      x.expErr = x.slvErr; x.expDone = 3 + x.waits; x.chkData = 1'b1;
    end
    return x;
  endfunction

  function automatic xfer_t rnd(input bit isWr);
    xfer_t x;
    x = mk(isWr, $urandom, $urandom, 4'($urandom), 3'($urandom),
           ($urandom_range(0, 5) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4),
           ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3), 1'b0, 0, 1'b0);
    return model(x);
  endfunction

  // APB slave: raises pready on access cycle index slvWait, otherwise drives junk
  initial begin : apb_slave
    bit inAcc;
    int idx;
    inAcc = 1'b0;
    idx = 0;
    forever begin
      @(posedge clk); #1;
      if (psel && penable) begin
        idx = inAcc ? idx + 1 : 0;
        inAcc = 1'b1;
      end else begin
        inAcc = 1'b0;
      end
      if (inAcc && idx == slvWait) begin
        pready = 1'b1; pslverr = slvErr; prdata = slvData;
      end else begin
        pready = 1'b0; pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
      end
    end
  end

  task automatic run_round(input xfer_t wx, input bit hasWr, input xfer_t rx, input bit hasRd);
    bit     pendW, pendR, busy, hs;
    xfer_t  cur;
    grant_t expG;
    int     t, held;
    logic   dv, de, ov, dr;
    pendW = hasWr; pendR = hasRd; busy = 1'b0; hs = 1'b0; t = 0; held = 0;
    cur = wx;
    @(posedge clk); #1;
    wr_req_valid = hasWr; wr_addr = hasWr ? wx.addr : $urandom;
    wr_data = hasWr ? wx.data : $urandom; wr_strb = wx.strb; wr_prot = wx.prot;
    rd_req_valid = hasRd; rd_addr = hasRd ? rx.addr : $urandom; rd_prot = rx.prot;
    wr_done_ready = 1'b0; rd_done_ready = 1'b0;
    for (int cyc = 0; cyc < 300 && (pendW || pendR || busy); cyc++) begin
      @(negedge clk);
      if (!busy) begin
        if (pendW && pendR) expG = (lastServed == GNT_RD) ? GNT_WR : GNT_RD;
        else expG = pendW ? GNT_WR : GNT_RD;
        check("wr_req_ready_idle", wr_req_ready, expG == GNT_WR);
        check("rd_req_ready_idle", rd_req_ready, expG == GNT_RD);
        acceptLog.push_back(expG);
        acceptCyc.push_back(cycNow);
        cur = (expG == GNT_WR) ? wx : rx;
        slvWait = cur.waits; slvErr = cur.slvErr; slvData = cur.rdata;
        busy = 1'b1; t = 0; held = 0; hs = 1'b0;
        @(posedge clk); #1;
        if (expG == GNT_WR) begin
          pendW = 1'b0; wr_req_valid = 1'b0; wr_addr = $urandom; wr_data = $urandom;
        end else begin
          pendR = 1'b0; rd_req_valid = 1'b0; rd_addr = $urandom;
        end
        if (cur.readyDelay == 0) begin
          if (cur.isWr) wr_done_ready = 1'b1; else rd_done_ready = 1'b1;
        end
      end else begin
        t++;
        dv = cur.isWr ? wr_done_valid : rd_done_valid;
        de = cur.isWr ? wr_done_err : rd_done_err;
        ov = cur.isWr ? rd_done_valid : wr_done_valid;
        dr = cur.isWr ? wr_done_ready : rd_done_ready;
        check("other_done_valid", ov, 1'b0);
        check("wr_req_ready_busy", wr_req_ready, 1'b0);
        check("rd_req_ready_busy", rd_req_ready, 1'b0);
        if (t < cur.expDone) begin
          check("done_valid_early", dv, 1'b0);
          check("psel_xfer", psel, 1'b1);
          check("penable_xfer", penable, t >= 2);
          check("pwrite", pwrite, cur.isWr);
          check("paddr", paddr, cur.addr);
          check("pprot", pprot, cur.prot);
          check("pwdata", pwdata, cur.isWr ? cur.data : 32'h0);
          check("pstrb", pstrb, cur.isWr ? cur.strb : 4'h0);
        end else begin
          check("done_valid", dv, 1'b1);
          check("done_err", de, cur.expErr);
          if (!cur.isWr && cur.chkData) check("rd_done_data", rd_done_data, cur.rdata);
          check("psel_resp", psel, 1'b0);
          check("penable_resp", penable, 1'b0);
          if (dr) hs = 1'b1; else held++;
        end
        @(posedge clk); #1;
        if (hs) begin
          busy = 1'b0;
          lastServed = cur.isWr ? GNT_WR : GNT_RD;
          wr_done_ready = 1'b0; rd_done_ready = 1'b0;
        end else if (held > 0 && held >= cur.readyDelay) begin
          if (cur.isWr) wr_done_ready = 1'b1; else rd_done_ready = 1'b1;
        end
      end
    end
    check("round_complete", {busy, pendW, pendR}, 3'b000);
    @(negedge clk);
    check("idle_wr_done_valid", wr_done_valid, 1'b0);
    check("idle_rd_done_valid", rd_done_valid, 1'b0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cycNow);
    $fatal(1, "watchdog");
  end

  initial begin : main
    dummy = mk(1'b0, 32'h0, 32'h0, 4'h0, 3'h0, 0, 1'b0, 32'h0, 0, 1'b0, 3, 1'b0);
    //        isWr  addr          data          strb  prot  wt  serr rdata         dly err done chk
    vec[0] = mk(1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 3'h0,   0, 0, 32'h0,          0, 0,  3, 1);
    vec[1] = mk(0, 32'h0000_0080, 32'h0,         4'h0, 3'h2,   3, 0, 32'h1234_5678,  0, 0,  6, 1);
    vec[2] = mk(1, 32'h0000_0100, 32'hA5A5_0001, 4'h3, 3'h1,   1, 1, 32'h0,          0, 1,  4, 1);
    vec[3] = mk(1, 32'h0000_0104, 32'h0BAD_F00D, 4'hF, 3'h0, 100, 0, 32'h0,          0, 1, 18, 0);
    vec[4] = mk(0, 32'h0000_0200, 32'h0,         4'h0, 3'h4,  15, 0, 32'hCAFE_0015,  0, 0, 18, 1);
    vec[5] = mk(0, 32'h0000_0204, 32'h0,         4'h0, 3'h0,  16, 0, 32'hCAFE_0016,  1, 1, 18, 0);
    vec[6] = mk(1, 32'h0000_0300, 32'h1357_9BDF, 4'h5, 3'h5,   2, 0, 32'h0,          5, 0,  5, 1);
    vec[7] = mk(0, 32'h0000_0304, 32'h0,         4'h0, 3'h7,   0, 1, 32'h7777_0000,  2, 1,  3, 1);

    // reset state, with junk on the request fields
    wr_addr = 32'hFFFF_FFFF; wr_data = 32'h1234_0000; rd_addr = 32'h5555_AAAA;
    #3;
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_pwrite", pwrite, 1'b0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pprot", pprot, 3'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_pstrb", pstrb, 4'h0);
    check("rst_done_valid", {wr_done_valid, rd_done_valid}, 2'b00);
    check("rst_done_err", {wr_done_err, rd_done_err}, 2'b00);
    check("rst_rd_done_data", rd_done_data, 32'h0);
    check("rst_req_ready", {wr_req_ready, rd_req_ready}, 2'b00);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_req_ready", {wr_req_ready, rd_req_ready}, 2'b00);

    // simultaneous requests from reset: W,R,W,R with a 4-cycle period
    acceptLog.delete(); acceptCyc.delete();
    run_round(model(mk(1, 32'h10, 32'hAAAA_0001, 4'hF, 3'h0, 0, 0, 32'h0, 0, 0, 0, 0)), 1'b1,
              model(mk(0, 32'h14, 32'h0, 4'h0, 3'h0, 0, 0, 32'hBBBB_0001, 0, 0, 0, 0)), 1'b1);
    run_round(model(mk(1, 32'h18, 32'hAAAA_0002, 4'hC, 3'h1, 1, 0, 32'h0, 0, 0, 0, 0)), 1'b1,
              model(mk(0, 32'h1C, 32'h0, 4'h0, 3'h1, 2, 0, 32'hBBBB_0002, 0, 0, 0, 0)), 1'b1);
    check("tie_count", acceptLog.size(), 4);
    if (acceptLog.size() >= 4) begin
      check("tie_order0", acceptLog[0], GNT_WR);
      check("tie_order1", acceptLog[1], GNT_RD);
      check("tie_order2", acceptLog[2], GNT_WR);
      check("tie_order3", acceptLog[3], GNT_RD);
      check("zero_wait_period", acceptCyc[1] - acceptCyc[0], 4);
    end

    // directed single-channel vectors
    for (int i = 0; i < 8; i++) begin
      if (vec[i].isWr) run_round(vec[i], 1'b1, dummy, 1'b0);
      else             run_round(dummy, 1'b0, vec[i], 1'b1);
    end

    // randomized rounds against the reference timing model
    for (int r = 0; r < 40; r++) begin
      bit hw, hr;
      hw = 1'($urandom_range(0, 1));
      hr = hw ? 1'($urandom_range(0, 1)) : 1'b1;
      run_round(rnd(1'b1), hw, rnd(1'b0), hr);
    end

    // reset during ACCESS abandons the transfer
    slvWait = 100;
    @(posedge clk); #1;
    wr_req_valid = 1'b1; wr_addr = 32'h0000_0440; wr_data = 32'h0; wr_strb = 4'hF;
    @(negedge clk);
    check("rstx_accept", wr_req_ready, 1'b1);
    @(posedge clk); #1; wr_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstx_in_access", {psel, penable}, 2'b11);
    #2 rst = 1'b0;
    #1;
    check("rstx_psel_async", psel, 1'b0);
    check("rstx_penable_async", penable, 1'b0);
    @(negedge clk); rst = 1'b1; lastServed = GNT_RD;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rstx_no_done", {wr_done_valid, rd_done_valid}, 2'b00);
      check("rstx_psel_idle", psel, 1'b0);
    end
    run_round(dummy, 1'b0, model(mk(0, 32'h0000_0480, 32'h0, 4'h0, 3'h0, 1, 0, 32'h600D_0001, 0, 0, 0, 0)), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
